// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains a FIFO read port and packs PACK words per valid/ready beat
// Optional FIFO_RD_PACKER_BIG_ENDIAN_EN puts the first word in the most-significant lane.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4,
  parameter int CNT_WIDTH  = $clog2(PACK) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fifo_empty,
  input  logic [DATA_WIDTH-1:0]      fifo_data,
  output logic                       fifo_r_en,
  input  logic                       flush,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_WIDTH*PACK-1:0] m_data,
  output logic [CNT_WIDTH-1:0]       m_count,
  output logic                       flush_busy
);
  localparam int BW = DATA_WIDTH * PACK;
  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(PACK);
  typedef enum logic [1:0] {F_IDLE, F_DRAIN, F_WAIT} fstate_t;
  fstate_t state, state_nxt;
  logic [BW-1:0] acc_data, acc_ins, out_src;
  logic [CNT_WIDTH-1:0] acc_cnt, base_cnt, load_cnt;
  logic [CNT_WIDTH:0] occ;
  logic rd_pending, out_free, xfer, mv, complete, full_load, part_load, load;
  int lane;
  // Beat-load decisions, lane insertion of the arriving word and read credit
  always_comb begin
    out_free  = !m_valid || m_ready;
    xfer      = m_valid && m_ready;
    mv        = acc_cnt == FULL && out_free;
    complete  = rd_pending && acc_cnt == FULL - 1'b1;
    full_load = mv || (out_free && complete);
    part_load = out_free && state == F_DRAIN && !rd_pending && acc_cnt != '0 && acc_cnt != FULL;
    load      = full_load || part_load;
    base_cnt  = mv ? '0 : acc_cnt;
`ifdef FIFO_RD_PACKER_BIG_ENDIAN_EN
    lane      = PACK - 1 - int'(base_cnt);
`else
    lane      = int'(base_cnt);
`endif
    acc_ins   = mv ? '0 : acc_data;
    if (rd_pending) acc_ins[lane*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
    out_src   = mv ? acc_data : acc_ins;
    load_cnt  = full_load ? FULL : acc_cnt;
    occ       = {1'b0, acc_cnt} + (CNT_WIDTH+1)'(rd_pending);
    fifo_r_en = rst_n && !fifo_empty && !flush_busy &&
                (occ < {1'b0, FULL} || (occ == {1'b0, FULL} && out_free));
  end
  // Accumulator, in-flight read tracking and output beat register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_data   <= '0;
      acc_cnt    <= '0;
      rd_pending <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_count    <= '0;
    end else begin
      rd_pending <= fifo_r_en;
      acc_data   <= (load && !mv) ? '0 : acc_ins;
      acc_cnt    <= mv ? CNT_WIDTH'(rd_pending) : load ? '0 : acc_cnt + CNT_WIDTH'(rd_pending);
      m_valid    <= load || (m_valid && !m_ready);
      if (load) begin
        m_data  <= out_src;
        m_count <= load_cnt;
      end
    end
  end
  // Flush state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= F_IDLE;
    else        state <= state_nxt;
  end
  // Flush next state: wait for the in-flight read, emit the partial beat, then wait for its transfer
  always_comb begin
    state_nxt = state == F_IDLE  ? (flush ? F_DRAIN : F_IDLE) :
                state == F_DRAIN ? (part_load ? F_WAIT : (!rd_pending && acc_cnt == '0) ? F_IDLE : F_DRAIN) :
                (xfer ? F_IDLE : F_WAIT);
  end
  // Flush outputs
  always_comb begin
    flush_busy = state != F_IDLE;
  end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: scoreboard bench with a registered-output FIFO model feeding the packer
module tb_fifo_rd_packer;
  localparam int DW = 8;
  localparam int PK = 4;
  localparam int CW = $clog2(PK) + 1;
  localparam int BW = DW * PK;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic fifo_r_en, m_valid, flush_busy;
  logic flush = 1'b0;
  logic m_ready = 1'b0;
  logic [BW-1:0] m_data;
  logic [CW-1:0] m_count;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t0;
  logic [DW-1:0] fq[$];
  logic [BW-1:0] exp_d[$];
  int exp_c[$];
  int xq[$];
  logic [BW-1:0] mdl_d = '0;
  int mdl_n = 0;
  logic hold_p = 1'b0;
  logic [BW-1:0] hold_d;
  logic [CW-1:0] hold_c;

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PK), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_r_en(fifo_r_en), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_count(m_count), .flush_busy(flush_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    int ln;
    fq.push_back(w);
    fifo_empty = 1'b0;
`ifdef FIFO_RD_PACKER_BIG_ENDIAN_EN
    ln = PK - 1 - mdl_n;
`else
    ln = mdl_n;
`endif
    mdl_d[ln*DW +: DW] = w;
    mdl_n++;
    if (mdl_n == PK) begin
      exp_d.push_back(mdl_d);
      exp_c.push_back(PK);
      mdl_d = '0;
      mdl_n = 0;
    end
  endtask

  task automatic model_flush();
    if (mdl_n > 0) begin
      exp_d.push_back(mdl_d);
      exp_c.push_back(mdl_n);
    end
    mdl_d = '0;
    mdl_n = 0;
  endtask

  task automatic wait_drain(input int lim);
    int n = 0;
    while (exp_d.size() > 0 && n < lim) begin
      tick();
      n++;
    end
    check("drain_left", exp_d.size(), 0);
    repeat (3) tick();
  endtask

  // FIFO model: registered data_out, one word per accepted read
  always @(posedge clk) begin
    cyc++;
    if (fifo_r_en && fq.size() > 0) begin
      fifo_data <= fq.pop_front();
      if (fq.size() == 0) fifo_empty <= 1'b1;
    end
  end

  // Output monitor: scoreboard compare, stall stability, read-while-empty guard
  always @(negedge clk) begin
    if (rst_n) begin
      check("ren_empty", fifo_r_en & fifo_empty, 0);
      if (hold_p) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, hold_d);
        check("hold_cnt", m_count, hold_c);
      end
      if (m_valid && m_ready) begin
        xq.push_back(cyc);
        if (exp_d.size() == 0) check("extra_beat", m_valid, 0);
        else begin
          check("beat_data", m_data, exp_d.pop_front());
          check("beat_cnt", m_count, exp_c.pop_front());
        end
      end
      hold_p = m_valid && !m_ready;
      hold_d = m_data;
      hold_c = m_count;
    end else hold_p = 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (2) tick();
    check("rst_valid", m_valid, 0);
    check("rst_count", m_count, 0);
    check("rst_data", m_data, 0);
    check("rst_ren", fifo_r_en, 0);
    check("rst_busy", flush_busy, 0);
    rst_n = 1'b1;
    tick();
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    wait_drain(60);
    xq.delete();
    t0 = cyc;
    for (int i = 1; i <= 16; i++) push(DW'(8'h40 + i));
    repeat (16) begin
      @(negedge clk);
      check("ren_cont", fifo_r_en, 1);
    end
    wait_drain(60);
    check("xfer_n", xq.size(), 4);
    for (int i = 0; i < xq.size() && i < 4; i++) check("xfer_time", xq[i] - t0, 5 + 4 * i);
    m_ready = 1'b0;
    for (int i = 1; i <= 12; i++) push(DW'(i));
    repeat (9) tick();
    @(negedge clk);
    check("ren_stall", fifo_r_en, 0);
    check("stall_valid", m_valid, 1);
    tick();
    m_ready = 1'b1;
    wait_drain(80);
    m_ready = 1'b0;
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    repeat (6) tick();
    model_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    @(negedge clk);
    check("flush_busy_hi", flush_busy, 1);
    check("flush_valid", m_valid, 1);
    check("flush_cnt", m_count, 3);
    tick();
    m_ready = 1'b1;
    tick();
    @(negedge clk);
    check("flush_busy_lo", flush_busy, 0);
    wait_drain(20);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("eflush_busy_hi", flush_busy, 1);
    tick();
    @(negedge clk);
    check("eflush_busy_lo", flush_busy, 0);
    check("eflush_valid", m_valid, 0);
    repeat (2) tick();
    push(8'h11);
    push(8'h22);
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", m_valid, 0);
    check("arst_count", m_count, 0);
    check("arst_data", m_data, 0);
    check("arst_ren", fifo_r_en, 0);
    check("arst_busy", flush_busy, 0);
    fq.delete();
    fifo_empty = 1'b1;
    mdl_d = '0;
    mdl_n = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) push(DW'(8'h30 + i));
    wait_drain(40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Downstream consumer of the synchronous FIFO.
- Drains the FIFO's read port (r_en / empty / registered data_out) and packs PACK consecutive DATA_WIDTH words into one wide beat.
- Presents beats on a valid/ready master stream toward the wide datapath.
- A flush input forces out a partial beat at end-of-frame.

Parameters:
- DATA_WIDTH, 8, width of one FIFO word
- PACK, 4, words per output beat (≥2)
- CNT_WIDTH, $clog2(PACK)+1, width of m_count

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- fifo_empty  input  1  FIFO empty flag
- fifo_data  input  DATA_WIDTH  FIFO data_out, valid the cycle after an accepted read
- fifo_r_en  output  1  FIFO read enable
- flush  input  1  single-cycle request to emit the partial beat
- m_valid  output  1  beat valid
- m_ready  input  1  downstream accept
- m_data  output  DATA_WIDTH*PACK  packed beat; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- m_count  output  CNT_WIDTH  number of valid lanes in the beat (1..PACK)
- flush_busy  output  1  high from flush capture until the partial beat is accepted, or until the flush is dropped

Behaviour:
- Reset (async, rst_n=0): fifo_r_en=0, m_valid=0, m_data=0, m_count=0, flush_busy=0, acc_cnt=0, rd_pending=0.
  - Reset mid-operation discards accumulated words and any in-flight read. The FIFO is reset separately.
- Read issue:
  - fifo_r_en is combinational and never asserted while fifo_empty=1, flush_busy=1, or rst_n=0.
  - rd_pending <= fifo_r_en. The word is captured from fifo_data exactly one cycle later.
  - Credit rule: words held + rd_pending must never exceed accumulator capacity (PACK words) plus output-register space freed this cycle. No word may ever be dropped or overwritten.
- Packing:
  - Words fill lanes 0,1,…,PACK-1 in arrival order.
  - The arrival that completes lane PACK-1 loads m_data/m_count=PACK directly on that edge if (!m_valid || m_ready). Otherwise the full beat is held in the accumulator and moved on the first edge where the output is free.
  - acc_cnt returns to 0, or to 1 if a word arrives in the same cycle.
- Output handshake:
  - A beat transfers when m_valid && m_ready.
  - m_data and m_count are stable while m_valid=1 and m_ready=0.
  - m_valid drops after a transfer unless a new beat loads on the same edge.
- Throughput: with m_ready=1 continuously and the FIFO never empty, one word is consumed per cycle in steady state (one beat every PACK cycles). The first beat is valid PACK+1 cycles after the first fifo_r_en.
- Flush:
  - flush=1 captured while flush_busy=0 sets flush_busy and blocks new reads.
  - After rd_pending clears, if acc_cnt>0, a beat with m_count=acc_cnt is loaded. Unused lanes are zero.
  - flush_busy clears when that beat transfers.
  - If acc_cnt=0 at that point, no beat is produced and flush_busy clears the next cycle.
  - flush while flush_busy=1 is ignored.
  - A full beat completing during flush is emitted normally with m_count=PACK.
- Simultaneous events:
  - Word arrival, beat transfer and flush capture in the same cycle are all honoured.
  - Flush applies to the words present after that arrival.
- Full-FIFO upstream is irrelevant here. Empty→non-empty transitions resume reads the same cycle fifo_empty falls.

Optional Feature:
- Macro: FIFO_RD_PACKER_BIG_ENDIAN_EN.
- Defined: the first word lands in the most-significant lane, i.e. lane PACK-1-i for the i-th word. A partial beat is zero-filled in its low lanes.
- Undefined: the little-endian lane order described above.
- No other behaviour changes.

Test Plan:
- Reset then push 8 words 0x01..0x08, m_ready=1 → two beats: m_data=0x04030201, then 0x08070605, each with m_count=4. fifo_r_en is never high while fifo_empty=1.
- Continuous FIFO, m_ready=1 → fifo_r_en high every cycle after start. m_valid asserts every 4th cycle, with no gaps.
- Push 12 words; m_ready=0 for 10 cycles, then 1 → fifo_r_en stalls after the accumulator fills. Beats arrive in order 0x04030201, 0x08070605, 0x0C0B0A09 with no loss; m_data is stable while stalled.
- Push 3 words 0xA1..0xA3, pulse flush → one beat m_data=0x00A3A2A1, m_count=3. flush_busy falls on transfer. A flush with an empty accumulator produces no beat.
- Assert rst_n=0 asynchronously mid-accumulation (2 words held) → all outputs 0 immediately. After release, the next 4 words form a clean beat.
- With FIFO_RD_PACKER_BIG_ENDIAN_EN defined, push 0x01..0x04 → m_data=0x01020304.
